add_sub_inverse_checker: RTL

//  Fault checker sitting at the result end of the ripple-carry add/sub unit.

---
 rtl/add_sub_inverse_checker.sv | 104 ++++++++++
 1 files changed

// File: rtl/add_sub_inverse_checker.sv
// Serial inverse-operation checker for a ripple add/sub result: rebuilds A from
// {COUT,SUM} and B one bit per cycle, then flags any disagreement with the operands.
module add_sub_inverse_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             in_ack,
  output logic             out_fault,
  output logic [WIDTH-1:0] out_mismatch,
  output logic [CNT_W-1:0] out_fault_cnt
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, mask;
  logic             mode, cout, carry;
  logic [IDX_W-1:0] idx;

  logic             s, b, r_bit, carry_nxt, carry_err, fault_nxt, last;
  logic [WIDTH-1:0] mask_nxt;

  // Operand shift registers expose the current bit at position 0.
  always_comb begin
    s         = s_sh[0];
    b         = b_sh[0];
    r_bit     = s ^ b ^ carry;
    carry_nxt = mode ? ((s & b) | (carry & (s ^ b)))
                     : ((~s & b) | (~(s ^ b) & carry));
    mask_nxt  = {r_bit ^ a_sh[0], mask[WIDTH-1:1]};
    // add was checked by subtracting: borrow must equal carry; sub checked by
    // adding back: carry out must be the inverse of the claimed no-borrow flag.
    carry_err = mode ? (carry_nxt == cout) : (carry_nxt != cout);
    fault_nxt = (|mask_nxt) | carry_err;
    last      = (idx == IDX_W'(WIDTH - 1));
  end

  assign out_ready    = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_mismatch = mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      s_sh          <= '0;
      mode          <= 1'b0;
      cout          <= 1'b0;
      carry         <= 1'b0;
      idx           <= '0;
      mask          <= '0;
      out_fault     <= 1'b0;
      out_fault_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= in_a;
          b_sh  <= in_b;
          s_sh  <= in_sum;
          mode  <= in_mode;
          cout  <= in_cout;
          carry <= 1'b0;
          idx   <= '0;
          mask  <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_sh >> 1;
          carry <= carry_nxt;
          mask  <= mask_nxt;
          idx   <= idx + 1'b1;
          if (last) begin
            state     <= DONE;
            idx       <= '0;
            out_fault <= fault_nxt;
            if (fault_nxt && !(&out_fault_cnt))
              out_fault_cnt <= out_fault_cnt + 1'b1;
          end
        end
        DONE: if (in_ack) begin
          state     <= IDLE;
          out_fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
